uart_cmd_ctrl: RTL and testbench

// - Command sequencer behind the UART receiver: consumes bytes validated by the RX path
//   (P_DATA + data_Valid pulse) and decodes them into register-file, ALU and TX-FIFO operations.
// - Returns read and ALU results to the UART TX path through the TX FIFO write port.
// - Owns the ALU clock-gate enable.

---
 rtl/uart_cmd_ctrl_if.sv | 36 +++
 rtl/uart_cmd_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_uart_cmd_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_cmd_ctrl_if.sv
// Signal bundle between the UART command sequencer and its RX, register-file, ALU and TX-FIFO neighbours.
// The sequencer uses the master modport; the surrounding datapath or bench uses the slave modport.
interface uart_cmd_ctrl_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4
);
   logic [DATA_WIDTH-1:0]   rx_p_data;
   logic                    rx_d_vld;
   logic                    rf_wr_en;
   logic                    rf_rd_en;
   logic [ADDR_WIDTH-1:0]   rf_addr;
   logic [DATA_WIDTH-1:0]   rf_wr_data;
   logic [DATA_WIDTH-1:0]   rf_rd_data;
   logic                    rf_rd_data_vld;
   logic                    alu_en;
   logic [3:0]              alu_fun;
   logic [2*DATA_WIDTH-1:0] alu_out;
   logic                    alu_out_vld;
   logic                    clk_gate_en;
   logic                    fifo_wr_en;
   logic [DATA_WIDTH-1:0]   fifo_wr_data;
   logic                    fifo_full;
   logic                    cmd_err;

   modport master (
      input  rx_p_data, rx_d_vld, rf_rd_data, rf_rd_data_vld, alu_out, alu_out_vld, fifo_full,
      output rf_wr_en, rf_rd_en, rf_addr, rf_wr_data, alu_en, alu_fun, clk_gate_en,
             fifo_wr_en, fifo_wr_data, cmd_err
   );

   modport slave (
      output rx_p_data, rx_d_vld, rf_rd_data, rf_rd_data_vld, alu_out, alu_out_vld, fifo_full,
      input  rf_wr_en, rf_rd_en, rf_addr, rf_wr_data, alu_en, alu_fun, clk_gate_en,
             fifo_wr_en, fifo_wr_data, cmd_err
   );
endinterface

// File: rtl/uart_cmd_ctrl.sv
// Command sequencer behind the UART receiver: decodes RX bytes into register-file, ALU and
// TX-FIFO operations. All outputs are registered.
//
// state    | meaning
// IDLE     | waiting for a command byte
// WR_ADDR  | write frame, waiting for address byte
// WR_DATA  | write frame, waiting for data byte
// RD_ADDR  | read frame, waiting for address byte
// RD_WAIT  | read issued, waiting for rf_rd_data_vld
// ALU_A    | ALU frame, waiting for operand A (stored at addr 0)
// ALU_B    | ALU frame, waiting for operand B (stored at addr 1)
// ALU_FUN  | waiting for function byte
// ALU_WAIT | ALU started, waiting for alu_out_vld
// TX_BYTE0 | pushing first (LSB) response byte
// TX_BYTE1 | pushing second (MSB) response byte
module uart_cmd_ctrl #(
   parameter int                    DATA_WIDTH  = 8,
   parameter int                    ADDR_WIDTH  = 4,
   parameter logic [DATA_WIDTH-1:0] CMD_WR      = 8'hAA,
   parameter logic [DATA_WIDTH-1:0] CMD_RD      = 8'hBB,
   parameter logic [DATA_WIDTH-1:0] CMD_ALU_OP  = 8'hCC,
   parameter logic [DATA_WIDTH-1:0] CMD_ALU_NOP = 8'hDD,
   parameter int                    WAIT_MAX    = 15
) (
   input logic             clk,
   input logic             rst,
   uart_cmd_ctrl_if.master bus
);
   localparam int CNT_W = $clog2(WAIT_MAX + 1);
   // Down-counter covers WAIT_MAX wait cycles; terminal count 0 on the last allowed cycle.
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_MAX - 1);

   typedef enum logic [3:0] {
      IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, ALU_A, ALU_B, ALU_FUN, ALU_WAIT, TX_BYTE0, TX_BYTE1
   } state_t;

   state_t                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] tx_lsb_q, tx_lsb_d, tx_msb_q, tx_msb_d;
   logic                  tx_two_q, tx_two_d;
   logic                  rf_wr_en_q, rf_wr_en_d, rf_rd_en_q, rf_rd_en_d;
   logic [ADDR_WIDTH-1:0] rf_addr_q, rf_addr_d;
   logic [DATA_WIDTH-1:0] rf_wr_data_q, rf_wr_data_d;
   logic                  alu_en_q, alu_en_d;
   logic [3:0]            alu_fun_q, alu_fun_d;
   logic                  clk_gate_en_q, clk_gate_en_d;
   logic                  fifo_wr_en_q, fifo_wr_en_d;
   logic [DATA_WIDTH-1:0] fifo_wr_data_q, fifo_wr_data_d;
   logic                  cmd_err_q, cmd_err_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q        <= IDLE;
         cnt_q          <= '0;
         tx_lsb_q       <= '0;
         tx_msb_q       <= '0;
         tx_two_q       <= 1'b0;
         rf_wr_en_q     <= 1'b0;
         rf_rd_en_q     <= 1'b0;
         rf_addr_q      <= '0;
         rf_wr_data_q   <= '0;
         alu_en_q       <= 1'b0;
         alu_fun_q      <= '0;
         clk_gate_en_q  <= 1'b0;
         fifo_wr_en_q   <= 1'b0;
         fifo_wr_data_q <= '0;
         cmd_err_q      <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         tx_lsb_q       <= tx_lsb_d;
         tx_msb_q       <= tx_msb_d;
         tx_two_q       <= tx_two_d;
         rf_wr_en_q     <= rf_wr_en_d;
         rf_rd_en_q     <= rf_rd_en_d;
         rf_addr_q      <= rf_addr_d;
         rf_wr_data_q   <= rf_wr_data_d;
         alu_en_q       <= alu_en_d;
         alu_fun_q      <= alu_fun_d;
         clk_gate_en_q  <= clk_gate_en_d;
         fifo_wr_en_q   <= fifo_wr_en_d;
         fifo_wr_data_q <= fifo_wr_data_d;
         cmd_err_q      <= cmd_err_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      tx_lsb_d       = tx_lsb_q;
      tx_msb_d       = tx_msb_q;
      tx_two_d       = tx_two_q;
      rf_wr_en_d     = 1'b0;
      rf_rd_en_d     = 1'b0;
      rf_addr_d      = rf_addr_q;
      rf_wr_data_d   = rf_wr_data_q;
      alu_en_d       = 1'b0;
      alu_fun_d      = alu_fun_q;
      clk_gate_en_d  = clk_gate_en_q;
      fifo_wr_en_d   = 1'b0;
      fifo_wr_data_d = fifo_wr_data_q;
      cmd_err_d      = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (bus.rx_d_vld) begin
               if (bus.rx_p_data == CMD_WR)           state_d = WR_ADDR;
               else if (bus.rx_p_data == CMD_RD)      state_d = RD_ADDR;
               else if (bus.rx_p_data == CMD_ALU_OP)  state_d = ALU_A;
               else if (bus.rx_p_data == CMD_ALU_NOP) state_d = ALU_FUN;
               else                                   cmd_err_d = 1'b1;
            end
         end
         WR_ADDR: begin
            if (bus.rx_d_vld) begin
               rf_addr_d = bus.rx_p_data[ADDR_WIDTH-1:0];
               state_d   = WR_DATA;
            end
         end
         WR_DATA: begin
            if (bus.rx_d_vld) begin
               rf_wr_data_d = bus.rx_p_data;
               rf_wr_en_d   = 1'b1;
               state_d      = IDLE;
            end
         end
         RD_ADDR: begin
            if (bus.rx_d_vld) begin
               rf_addr_d  = bus.rx_p_data[ADDR_WIDTH-1:0];
               rf_rd_en_d = 1'b1;
               cnt_d      = CNT_LOAD;
               state_d    = RD_WAIT;
            end
         end
         RD_WAIT: begin
            cmd_err_d = bus.rx_d_vld;
            if (bus.rf_rd_data_vld) begin
               tx_lsb_d = bus.rf_rd_data;
               tx_two_d = 1'b0;
               state_d  = TX_BYTE0;
            end else if (cnt_q == '0) begin
               cmd_err_d = 1'b1;
               state_d   = IDLE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ALU_A, ALU_B: begin
            if (bus.rx_d_vld) begin
               rf_addr_d    = (state_q == ALU_A) ? ADDR_WIDTH'(0) : ADDR_WIDTH'(1);
               rf_wr_data_d = bus.rx_p_data;
               rf_wr_en_d   = 1'b1;
               state_d      = (state_q == ALU_A) ? ALU_B : ALU_FUN;
            end
         end
         ALU_FUN: begin
            if (bus.rx_d_vld) begin
               alu_fun_d     = bus.rx_p_data[3:0];
               alu_en_d      = 1'b1;
               clk_gate_en_d = 1'b1;
               cnt_d         = CNT_LOAD;
               state_d       = ALU_WAIT;
            end
         end
         ALU_WAIT: begin
            cmd_err_d = bus.rx_d_vld;
            if (bus.alu_out_vld) begin
               tx_lsb_d      = bus.alu_out[DATA_WIDTH-1:0];
               tx_msb_d      = bus.alu_out[2*DATA_WIDTH-1:DATA_WIDTH];
               tx_two_d      = 1'b1;
               clk_gate_en_d = 1'b0;
               state_d       = TX_BYTE0;
            end else if (cnt_q == '0) begin
               cmd_err_d     = 1'b1;
               clk_gate_en_d = 1'b0;
               state_d       = IDLE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         TX_BYTE0, TX_BYTE1: begin
            // A full FIFO simply stalls the push; stray RX bytes are dropped meanwhile.
            cmd_err_d = bus.rx_d_vld;
            if (!bus.fifo_full) begin
               fifo_wr_en_d   = 1'b1;
               fifo_wr_data_d = (state_q == TX_BYTE0) ? tx_lsb_q : tx_msb_q;
               state_d        = (state_q == TX_BYTE0 && tx_two_q) ? TX_BYTE1 : IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.rf_wr_en     = rf_wr_en_q;
   assign bus.rf_rd_en     = rf_rd_en_q;
   assign bus.rf_addr      = rf_addr_q;
   assign bus.rf_wr_data   = rf_wr_data_q;
   assign bus.alu_en       = alu_en_q;
   assign bus.alu_fun      = alu_fun_q;
   assign bus.clk_gate_en  = clk_gate_en_q;
   assign bus.fifo_wr_en   = fifo_wr_en_q;
   assign bus.fifo_wr_data = fifo_wr_data_q;
   assign bus.cmd_err      = cmd_err_q;
endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Bench for uart_cmd_ctrl: table of frames plus random frames checked against a frame-level
// model, with hand sequences for timing, timeout, dropped-byte and reset corners.
module tb_uart_cmd_ctrl;
   localparam int WAIT_MAX = 15;

   typedef struct {
      logic [7:0]  b0, b1, b2, b3;
      int          dly;      // responder latency in cycles, 0 = never responds
      logic [7:0]  rd;
      logic [15:0] alu;
      int          full;     // cycles of fifo_full starting with alu_out_vld
      int          enp;
      logic [7:0]  ep0, ep1;
      int          eerr;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   uart_cmd_ctrl_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus ();
   uart_cmd_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .WAIT_MAX(WAIT_MAX)) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int rsp_dly = 0;
   int rsp_full = 0;
   logic [7:0]  rsp_rd  = 8'h00;
   logic [15:0] rsp_alu = 16'h0000;

   logic [11:0] wr_q[$];
   logic [3:0]  rd_q[$];
   logic [3:0]  alu_q[$];
   logic [7:0]  push_q[$];
   int          err_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: outputs settle after posedge; inputs change only at negedge.
   initial forever begin
      @(posedge clk);
      #1;
      if (rst) begin
         if (bus.rf_wr_en) wr_q.push_back({bus.rf_addr, bus.rf_wr_data});
         if (bus.rf_rd_en) rd_q.push_back(bus.rf_addr);
         if (bus.alu_en)   alu_q.push_back(bus.alu_fun);
         if (bus.fifo_wr_en) begin
            push_q.push_back(bus.fifo_wr_data);
            check("push_while_full", 32'(bus.fifo_full), 32'd0);
         end
         if (bus.cmd_err) err_cnt++;
      end
   end

   // Register-file read responder.
   initial forever begin
      @(negedge clk);
      if (rst && bus.rf_rd_en && rsp_dly > 0) begin
         repeat (rsp_dly - 1) @(negedge clk);
         bus.rf_rd_data     = rsp_rd;
         bus.rf_rd_data_vld = 1'b1;
         @(negedge clk);
         bus.rf_rd_data_vld = 1'b0;
      end
   end

   // ALU responder, optionally holding the FIFO full after the result.
   initial forever begin
      @(negedge clk);
      if (rst && bus.alu_en && rsp_dly > 0) begin
         repeat (rsp_dly - 1) @(negedge clk);
         bus.alu_out     = rsp_alu;
         bus.alu_out_vld = 1'b1;
         check("gate_during_wait", 32'(bus.clk_gate_en), 32'd1);
         if (rsp_full > 0) bus.fifo_full = 1'b1;
         @(negedge clk);
         bus.alu_out_vld = 1'b0;
         if (rsp_full > 0) begin
            repeat (rsp_full - 1) @(negedge clk);
            bus.fifo_full = 1'b0;
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   function automatic vec_t mk(input logic [7:0] b0, b1, b2, b3, input int dly,
                               input logic [7:0] rd, input logic [15:0] alu, input int full,
                               input int enp, input logic [7:0] ep0, ep1, input int eerr);
      vec_t v;
      v.b0 = b0; v.b1 = b1; v.b2 = b2; v.b3 = b3; v.dly = dly; v.rd = rd; v.alu = alu;
      v.full = full; v.enp = enp; v.ep0 = ep0; v.ep1 = ep1; v.eerr = eerr;
      return v;
   endfunction

   function automatic int frame_len(input logic [7:0] c);
      case (c)
         8'hAA:   return 3;
         8'hBB:   return 2;
         8'hCC:   return 4;
         8'hDD:   return 2;
         default: return 1;
      endcase
   endfunction

   // Frame-level reference: what the TX path and error line should show for one frame.
   function automatic vec_t model(input vec_t v);
      vec_t r = v;
      r.enp = 0; r.ep0 = 8'h00; r.ep1 = 8'h00; r.eerr = 0;
      case (v.b0)
         8'hAA: ;
         8'hBB: if (v.dly > 0 && v.dly <= WAIT_MAX) begin r.enp = 1; r.ep0 = v.rd; end
                else r.eerr = 1;
         8'hCC, 8'hDD:
                if (v.dly > 0 && v.dly <= WAIT_MAX) begin
                   r.enp = 2; r.ep0 = v.alu[7:0]; r.ep1 = v.alu[15:8];
                end else r.eerr = 1;
         default: r.eerr = 1;
      endcase
      return r;
   endfunction

   task automatic send_byte(input logic [7:0] b);
      bus.rx_p_data = b;
      bus.rx_d_vld  = 1'b1;
      @(negedge clk);
      bus.rx_d_vld  = 1'b0;
   endtask

   task automatic begin_frame(input vec_t v);
      wr_q.delete(); rd_q.delete(); alu_q.delete(); push_q.delete();
      err_cnt  = 0;
      rsp_dly  = v.dly;
      rsp_rd   = v.rd;
      rsp_alu  = v.alu;
      rsp_full = v.full;
   endtask

   task automatic check_frame(input vec_t v, input string tag);
      logic [11:0] ewr[$];
      logic [3:0]  erd[$];
      logic [3:0]  ealu[$];
      case (v.b0)
         8'hAA: ewr.push_back({v.b1[3:0], v.b2});
         8'hBB: erd.push_back(v.b1[3:0]);
         8'hCC: begin
            ewr.push_back({4'd0, v.b1});
            ewr.push_back({4'd1, v.b2});
            ealu.push_back(v.b3[3:0]);
         end
         8'hDD: ealu.push_back(v.b1[3:0]);
         default: ;
      endcase
      check({tag, "/wr_count"}, 32'(wr_q.size()), 32'(ewr.size()));
      foreach (ewr[i]) if (i < wr_q.size()) check({tag, "/wr"}, 32'(wr_q[i]), 32'(ewr[i]));
      check({tag, "/rd_count"}, 32'(rd_q.size()), 32'(erd.size()));
      foreach (erd[i]) if (i < rd_q.size()) check({tag, "/rd_addr"}, 32'(rd_q[i]), 32'(erd[i]));
      check({tag, "/alu_count"}, 32'(alu_q.size()), 32'(ealu.size()));
      foreach (ealu[i]) if (i < alu_q.size()) check({tag, "/alu_fun"}, 32'(alu_q[i]), 32'(ealu[i]));
      check({tag, "/push_count"}, 32'(push_q.size()), 32'(v.enp));
      if (v.enp >= 1 && push_q.size() >= 1) check({tag, "/push0"}, 32'(push_q[0]), 32'(v.ep0));
      if (v.enp >= 2 && push_q.size() >= 2) check({tag, "/push1"}, 32'(push_q[1]), 32'(v.ep1));
      check({tag, "/err_count"}, 32'(err_cnt), 32'(v.eerr));
      check({tag, "/gate_idle"}, 32'(bus.clk_gate_en), 32'd0);
   endtask

   task automatic run_frame(input vec_t v, input string tag);
      logic [7:0] bytes[4];
      bytes[0] = v.b0; bytes[1] = v.b1; bytes[2] = v.b2; bytes[3] = v.b3;
      begin_frame(v);
      for (int i = 0; i < frame_len(v.b0); i++) begin
         send_byte(bytes[i]);
         @(negedge clk);
      end
      repeat (45) @(negedge clk);
      check_frame(v, tag);
   endtask

   vec_t tbl[10];

   initial begin
      vec_t v;
      int   k;
      bus.rx_p_data = 8'h00; bus.rx_d_vld = 1'b0;
      bus.rf_rd_data = 8'h00; bus.rf_rd_data_vld = 1'b0;
      bus.alu_out = 16'h0000; bus.alu_out_vld = 1'b0;
      bus.fifo_full = 1'b0;

      //            b0     b1     b2     b3     dly rd     alu       full enp ep0    ep1    err
      tbl[0] = mk(8'hAA, 8'h05, 8'h3C, 8'h00, 0,  8'h00, 16'h0000, 0,   0, 8'h00, 8'h00, 0);
      tbl[1] = mk(8'hBB, 8'h07, 8'h00, 8'h00, 2,  8'h9E, 16'h0000, 0,   1, 8'h9E, 8'h00, 0);
      tbl[2] = mk(8'hCC, 8'h12, 8'h34, 8'h00, 3,  8'h00, 16'h0046, 0,   2, 8'h46, 8'h00, 0);
      tbl[3] = mk(8'hDD, 8'h02, 8'h00, 8'h00, 2,  8'h00, 16'hA55A, 5,   2, 8'h5A, 8'hA5, 0);
      tbl[4] = mk(8'h5A, 8'h00, 8'h00, 8'h00, 0,  8'h00, 16'h0000, 0,   0, 8'h00, 8'h00, 1);
      tbl[5] = mk(8'hAA, 8'h0F, 8'hFF, 8'h00, 0,  8'h00, 16'h0000, 0,   0, 8'h00, 8'h00, 0);
      tbl[6] = mk(8'hBB, 8'h03, 8'h00, 8'h00, 15, 8'h77, 16'h0000, 0,   1, 8'h77, 8'h00, 0);
      tbl[7] = mk(8'hBB, 8'h03, 8'h00, 8'h00, 0,  8'h00, 16'h0000, 0,   0, 8'h00, 8'h00, 1);
      tbl[8] = mk(8'hDD, 8'h0F, 8'h00, 8'h00, 0,  8'h00, 16'h0000, 0,   0, 8'h00, 8'h00, 1);
      tbl[9] = mk(8'hCC, 8'hFF, 8'h01, 8'h07, 15, 8'h00, 16'hFFFE, 1,   2, 8'hFE, 8'hFF, 0);

      repeat (3) @(negedge clk);
      check("reset_outputs", {22'd0, bus.rf_wr_en, bus.rf_rd_en, bus.alu_en, bus.clk_gate_en,
                              bus.fifo_wr_en, bus.cmd_err, bus.alu_fun}, 32'd0);
      rst = 1'b1;
      @(negedge clk);

      foreach (tbl[i]) run_frame(tbl[i], $sformatf("vec%0d", i));

      // Write strobe lands exactly one cycle after the data byte.
      v = mk(8'hAA, 8'h05, 8'h3C, 8'h00, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 8'h00, 0);
      begin_frame(v);
      send_byte(8'hAA); @(negedge clk);
      send_byte(8'h05); @(negedge clk);
      send_byte(8'h3C);
      check("wr_strobe", {23'd0, bus.rf_wr_en, bus.rf_addr, bus.rf_wr_data[3:0]}, {23'd0, 1'b1, 4'h5, 4'hC});
      check("wr_data", 32'(bus.rf_wr_data), 32'h3C);
      @(negedge clk);
      check("wr_strobe_len", 32'(bus.rf_wr_en), 32'd0);
      repeat (10) @(negedge clk);
      check_frame(v, "wr_timing");

      // Read timeout fires exactly WAIT_MAX cycles after the read strobe.
      v = mk(8'hBB, 8'h03, 8'h00, 8'h00, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 8'h00, 1);
      begin_frame(v);
      send_byte(8'hBB); @(negedge clk);
      send_byte(8'h03);
      check("rd_strobe", 32'(bus.rf_rd_en), 32'd1);
      k = 0;
      while (k < 40 && !bus.cmd_err) begin
         @(negedge clk);
         k++;
      end
      check("rd_timeout_cycles", 32'(k), 32'(WAIT_MAX));
      repeat (10) @(negedge clk);
      check_frame(v, "rd_timeout");

      // Byte arriving during RD_WAIT is dropped with an error; the read still completes.
      v = mk(8'hBB, 8'h07, 8'h00, 8'h00, 8, 8'hC3, 16'h0000, 0, 1, 8'hC3, 8'h00, 1);
      begin_frame(v);
      send_byte(8'hBB); @(negedge clk);
      send_byte(8'h07); @(negedge clk);
      repeat (2) @(negedge clk);
      send_byte(8'h55);
      repeat (40) @(negedge clk);
      check_frame(v, "drop_rd_wait");

      // Byte arriving while the push is stalled on a full FIFO.
      v = mk(8'hDD, 8'h01, 8'h00, 8'h00, 1, 8'h00, 16'hBEEF, 4, 2, 8'hEF, 8'hBE, 1);
      begin_frame(v);
      send_byte(8'hDD); @(negedge clk);
      send_byte(8'h01);
      k = 0;
      while (k < 30 && !bus.fifo_full) begin
         @(negedge clk);
         k++;
      end
      check("full_seen", 32'(bus.fifo_full), 32'd1);
      send_byte(8'h66);
      repeat (40) @(negedge clk);
      check_frame(v, "drop_full");

      // Reset in the middle of an ALU frame.
      v = mk(8'hCC, 8'h12, 8'h34, 8'h05, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 8'h00, 0);
      begin_frame(v);
      send_byte(8'hCC); @(negedge clk);
      send_byte(8'h12); @(negedge clk);
      send_byte(8'h34); @(negedge clk);
      send_byte(8'h05); @(negedge clk);
      check("gate_before_reset", 32'(bus.clk_gate_en), 32'd1);
      rst = 1'b0;
      #1;
      check("reset_mid_frame", {bus.rf_wr_en, bus.rf_rd_en, bus.alu_en, bus.clk_gate_en,
                                bus.fifo_wr_en, bus.cmd_err, bus.alu_fun, bus.rf_addr,
                                bus.rf_wr_data, bus.fifo_wr_data}, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      run_frame(mk(8'hAA, 8'h09, 8'h81, 8'h00, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 8'h00, 0),
                "after_reset");

      // Randomised frames against the frame-level model.
      for (int n = 0; n < 40; n++) begin
         int sel;
         sel = int'($urandom_range(0, 4));
         v.b1 = 8'($urandom); v.b2 = 8'($urandom); v.b3 = 8'($urandom);
         case (sel)
            0: v.b0 = 8'hAA;
            1: v.b0 = 8'hBB;
            2: v.b0 = 8'hCC;
            3: v.b0 = 8'hDD;
            default: begin
               v.b0 = 8'($urandom);
               while (frame_len(v.b0) != 1) v.b0 = 8'($urandom);
            end
         endcase
         v.dly  = ($urandom_range(0, 9) < 8) ? int'($urandom_range(1, WAIT_MAX)) : 0;
         v.rd   = 8'($urandom);
         v.alu  = 16'($urandom);
         v.full = int'($urandom_range(0, 4));
         run_frame(model(v), $sformatf("rnd%0d", n));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
